// File: rtl/crc16.sv
// Parallel CRC-16/XMODEM accumulator (poly 0x1021, init 0x0000): folds one
// 64-bit word per clock into a running CRC. Define CRC16_VALID_EN to add a data_valid qualifier.
module crc16 (
    input  logic        clk,
    input  logic        rst,
    input  logic [63:0] data_in,
`ifdef CRC16_VALID_EN
    input  logic        data_valid,
`endif
    output logic [15:0] crc_out
);

    logic [15:0] crc;
    logic [15:0] crc_next;
    logic        update_en;

    // Handshake: data_in is consumed on every rising edge where data_valid is
    // high (or on every edge when the qualifier is not built in). There is no
    // backpressure; the word is absorbed in the cycle it is presented.
`ifdef CRC16_VALID_EN
    assign update_en = data_valid;
`else
    assign update_en = 1'b1;
`endif

    // 64 serial LFSR steps, MSB first; synthesis flattens this into an XOR tree.
    function automatic logic [15:0] fold_word(input logic [15:0] state,
                                              input logic [63:0] word);
        logic [15:0] c;
        logic        fb;
        c = state;
        for (int i = 63; i >= 0; i--) begin
            fb = c[15] ^ word[i];
            c  = {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
        end
        return c;
    endfunction

    always_comb begin
        crc_next = crc;
        if (update_en) begin
            crc_next = fold_word(crc, data_in);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            crc <= 16'h0000;
        end else begin
            crc <= crc_next;
        end
    end

    assign crc_out = crc;

endmodule

// File: tb/tb_crc16.sv
// Self-checking bench for crc16: driver pushes model results into exp_q, a
// monitor pops and compares after each rising edge.
module tb_crc16;

    logic        clk;
    logic        rst;
    logic [63:0] data_in;
`ifdef CRC16_VALID_EN
    logic        data_valid;
`endif
    logic [15:0] crc_out;

    logic [15:0] exp_q[$];
    logic [15:0] model;
    int          n_vec;
    int          n_err;

    crc16 dut (
        .clk        (clk),
        .rst        (rst),
        .data_in    (data_in),
`ifdef CRC16_VALID_EN
        .data_valid (data_valid),
`endif
        .crc_out    (crc_out)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // CRC as polynomial remainder: (state * x^64 + word * x^16) mod P(x).
    function automatic logic [15:0] ref_f(input logic [15:0] s, input logic [63:0] d);
        logic [79:0] m;
        m = {s, 64'h0} ^ {d, 16'h0};
        for (int i = 79; i >= 16; i--) begin
            if (m[i]) m[i -: 17] = m[i -: 17] ^ 17'h11021;
        end
        return m[15:0];
    endfunction

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: crc_out=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                check("scoreboard", crc_out, exp_q.pop_front());
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic drive(input logic [63:0] d, input logic v, input logic r);
        @(negedge clk);
        rst     = r;
        data_in = d;
`ifdef CRC16_VALID_EN
        data_valid = v;
        if (!r)     model = 16'h0000;
        else if (v) model = ref_f(model, d);
`else
        if (!r) model = 16'h0000;
        else    model = ref_f(model, d);
`endif
        exp_q.push_back(model);
    endtask

    // Asynchronous reset between edges; output must clear before the next edge.
    task automatic async_reset(input string name);
        @(negedge clk);
        #2;
        rst   = 1'b0;
        model = 16'h0000;
        #1;
        check(name, crc_out, 16'h0000);
    endtask

    task automatic one_word_from_reset(input logic [63:0] d, output logic [15:0] got);
        async_reset("reset_before_word");
        drive(d, 1'b1, 1'b1);
        @(posedge clk);
        #2;
        got = crc_out;
    endtask

    logic [63:0] w;
    logic [15:0] r1, r2, r3;
    localparam logic [63:0] PAT_A = 64'h0123456789ABCDEF;
    localparam logic [63:0] PAT_B = 64'hFEDCBA9876543210;

    initial begin
        n_vec   = 0;
        n_err   = 0;
        model   = 16'h0000;
        rst     = 1'b0;
        data_in = PAT_A;
`ifdef CRC16_VALID_EN
        data_valid = 1'b1;
`endif
        #1;
        check("reset_initial", crc_out, 16'h0000);

        // Reset held across three edges with nonzero data.
        repeat (3) drive(PAT_A, 1'b1, 1'b0);

        // Single-bit words.
        drive(64'h1, 1'b1, 1'b1);
        @(posedge clk); #2;
        check("single_bit_0", crc_out, 16'h1021);
        async_reset("reset_after_bit0");
        drive(64'h2, 1'b1, 1'b1);
        @(posedge clk); #2;
        check("single_bit_1", crc_out, 16'h2042);

        // Zero stream.
        async_reset("reset_before_zero");
        repeat (5) drive(64'h0, 1'b1, 1'b1);

        // Linearity across three reset runs.
        one_word_from_reset(PAT_A, r1);
        one_word_from_reset(PAT_B, r2);
        one_word_from_reset(PAT_A ^ PAT_B, r3);
        check("linearity", r3, ref_f(16'h0, PAT_A) ^ ref_f(16'h0, PAT_B));
        check("linearity_xor", r1 ^ r2, ref_f(16'h0, PAT_A ^ PAT_B));

        // Random stream.
        async_reset("reset_before_random");
        drive(PAT_B, 1'b1, 1'b1);
        repeat (5) drive({$urandom, $urandom}, 1'b1, 1'b1);
        repeat (40) drive({$urandom, $urandom}, 1'b1, 1'b1);

        // Mid-stream asynchronous reset, then resume.
        async_reset("reset_mid_stream");
        repeat (20) drive({$urandom, $urandom}, 1'b1, 1'b1);

`ifdef CRC16_VALID_EN
        // Valid gating: invalid cycles carry garbage and must hold the CRC.
        async_reset("reset_before_gating");
        r1 = 16'h0000;
        for (int i = 0; i < 30; i++) begin
            w = {$urandom, $urandom};
            if ($urandom_range(0, 2) == 0) begin
                drive(w, 1'b0, 1'b1);
            end else begin
                r1 = ref_f(r1, w);
                drive(w, 1'b1, 1'b1);
            end
        end
        @(posedge clk); #2;
        check("gating_final", crc_out, r1);
`endif

        // Drain the scoreboard with a bounded wait.
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
        #2;
        if (exp_q.size() != 0) begin
            n_vec++;
            n_err++;
            $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
